// File: rtl/snake_motion_unit.sv
// snake_motion_unit: body shift register, direction latch, step timer, wall/self collision and render query.
// Optional SNAKE_WRAP_WALLS_EN: moves off an edge re-enter on the opposite edge and hit_wall never sets.
module snake_motion_unit #(
  parameter int GRID_W      = 40,
  parameter int GRID_H      = 30,
  parameter int X_W         = 6,
  parameter int Y_W         = 5,
  parameter int MAX_LEN     = 16,
  parameter int INIT_LEN    = 3,
  parameter int STEP_CYCLES = 25000000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     game_status,
  input  logic           restart,
  input  logic           key1_press,
  input  logic           key2_press,
  input  logic           key3_press,
  input  logic           key4_press,
  input  logic           apple_eat,
  input  logic [X_W-1:0] query_x,
  input  logic [Y_W-1:0] query_y,
  output logic           hit_wall,
  output logic           hit_body,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [4:0]     snake_len,
  output logic           step_pulse,
  output logic           body_at_q
);
  localparam int CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] ST_PLAY  = 2'b10;
  localparam logic signed [X_W:0] X_LIM = GRID_W[X_W:0];
  localparam logic signed [Y_W:0] Y_LIM = GRID_H[Y_W:0];
  localparam logic signed [X_W:0] X_ONE = {{X_W{1'b0}}, 1'b1};
  localparam logic signed [Y_W:0] Y_ONE = {{Y_W{1'b0}}, 1'b1};
  localparam logic [Y_W-1:0] Y_MID = Y_W'(GRID_H / 2);

  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  logic [MAX_LEN-1:0][X_W-1:0] seg_x, init_x;
  logic [MAX_LEN-1:0][Y_W-1:0] seg_y;
  dir_t             dir, pend_dir, key_dir;
  logic [CNT_W-1:0] cnt;
  logic             grow_pend;
  logic             key_any, key_ok, running, step_fire, grow;
  logic             x_out, y_out, off_grid, body_hit, query_hit;
  logic signed [X_W:0] dx, sx;
  logic signed [Y_W:0] dy, sy;
  logic [X_W-1:0]   nx;
  logic [Y_W-1:0]   ny;
  logic [4:0]       chk_len;

  assign head_x = seg_x[0];
  assign head_y = seg_y[0];

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) init_x[i] = X_W'(GRID_W / 2 - i);
  end

  // Reversal is judged against the last committed move, not the pending one.
  always_comb begin
    key_any = key1_press | key2_press | key3_press | key4_press;
    key_dir = key1_press ? D_UP : key2_press ? D_DOWN : key3_press ? D_LEFT : D_RIGHT;
    key_ok  = key_any && (game_status == ST_START || game_status == ST_PLAY) &&
              (key_dir != dir_t'(dir ^ 2'b01));
  end

  assign running   = (game_status == ST_PLAY) && !hit_wall && !hit_body;
  assign step_fire = running && (cnt == CNT_LAST);
  assign grow      = grow_pend | apple_eat;

  // One extra sign bit so stepping left of x=0 / above y=0 is seen as negative.
  always_comb begin
    dx = '0;
    dy = '0;
    case (pend_dir)
      D_UP:    dy = '1;
      D_DOWN:  dy = Y_ONE;
      D_LEFT:  dx = '1;
      default: dx = X_ONE;
    endcase
    sx    = $signed({1'b0, seg_x[0]}) + dx;
    sy    = $signed({1'b0, seg_y[0]}) + dy;
    x_out = sx[X_W] || (sx >= X_LIM);
    y_out = sy[Y_W] || (sy >= Y_LIM);
`ifdef SNAKE_WRAP_WALLS_EN
    off_grid = 1'b0;
    nx = sx[X_W] ? X_W'(GRID_W - 1) : x_out ? '0 : sx[X_W-1:0];
    ny = sy[Y_W] ? Y_W'(GRID_H - 1) : y_out ? '0 : sy[Y_W-1:0];
`else
    off_grid = x_out || y_out;
    nx = sx[X_W-1:0];
    ny = sy[Y_W-1:0];
`endif
  end

  // Without growth the tail vacates this step, so it cannot be hit.
  always_comb begin
    chk_len   = grow ? snake_len : snake_len - 5'd1;
    body_hit  = 1'b0;
    query_hit = 1'b0;
    for (int i = 1; i < MAX_LEN; i++)
      if (i < int'(chk_len) && seg_x[i] == nx && seg_y[i] == ny) body_hit = 1'b1;
    for (int i = 0; i < MAX_LEN; i++)
      if (i < int'(snake_len) && seg_x[i] == query_x && seg_y[i] == query_y) query_hit = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_x      <= init_x;
      seg_y      <= {MAX_LEN{Y_MID}};
      dir        <= D_RIGHT;
      pend_dir   <= D_RIGHT;
      snake_len  <= 5'(INIT_LEN);
      hit_wall   <= 1'b0;
      hit_body   <= 1'b0;
      step_pulse <= 1'b0;
      body_at_q  <= 1'b0;
      cnt        <= '0;
      grow_pend  <= 1'b0;
    end else if (restart) begin
      seg_x      <= init_x;
      seg_y      <= {MAX_LEN{Y_MID}};
      dir        <= D_RIGHT;
      pend_dir   <= D_RIGHT;
      snake_len  <= 5'(INIT_LEN);
      hit_wall   <= 1'b0;
      hit_body   <= 1'b0;
      step_pulse <= 1'b0;
      body_at_q  <= 1'b0;
      cnt        <= '0;
      grow_pend  <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      body_at_q  <= query_hit;
      cnt        <= (!running || step_fire) ? '0 : cnt + 1'b1;
      if (key_ok) pend_dir <= key_dir;
      if (apple_eat) grow_pend <= 1'b1;
      if (step_fire) begin
        if (off_grid) hit_wall <= 1'b1;
        else if (body_hit) hit_body <= 1'b1;
        else begin
          // Full-depth shift: when growing, slot len picks up the old tail.
          seg_x      <= {seg_x[MAX_LEN-2:0], nx};
          seg_y      <= {seg_y[MAX_LEN-2:0], ny};
          dir        <= pend_dir;
          step_pulse <= 1'b1;
          grow_pend  <= 1'b0;
          if (grow && snake_len < 5'(MAX_LEN)) snake_len <= snake_len + 5'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_snake_motion_unit.sv
// Bench for snake_motion_unit: directed vector table, hand-written turn/collision sequences and
// randomized play against a queue-based model of the snake.
module tb_snake_motion_unit;
  localparam int STEP = 4, GW = 40, GH = 30, ML = 16, IL = 3;
  localparam int UP = 0, DN = 1, LT = 2, RT = 3;

  logic clk = 1'b0, reset = 1'b1, restart = 1'b0, apple = 1'b0;
  logic k1 = 1'b0, k2 = 1'b0, k3 = 1'b0, k4 = 1'b0;
  logic [1:0] status = 2'b00;
  logic [5:0] qx = '0;
  logic [4:0] qy = '0;
  logic hit_wall, hit_body, step_pulse, body_at_q;
  logic [5:0] head_x;
  logic [4:0] head_y, snake_len;

  always #5 clk = ~clk;

  snake_motion_unit #(.GRID_W(GW), .GRID_H(GH), .X_W(6), .Y_W(5), .MAX_LEN(ML),
                      .INIT_LEN(IL), .STEP_CYCLES(STEP)) dut (
    .clk(clk), .reset(reset), .game_status(status), .restart(restart),
    .key1_press(k1), .key2_press(k2), .key3_press(k3), .key4_press(k4),
    .apple_eat(apple), .query_x(qx), .query_y(qy),
    .hit_wall(hit_wall), .hit_body(hit_body), .head_x(head_x), .head_y(head_y),
    .snake_len(snake_len), .step_pulse(step_pulse), .body_at_q(body_at_q));

  int passed = 0, total = 0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Reference model: body as coordinate queues, head at index 0.
  int bx[$], by[$];
  int mdir, mpend, mcnt;
  bit mgrow, mwall, mbody, mstep, mq;

  task automatic m_init();
    bx.delete(); by.delete();
    for (int i = 0; i < IL; i++) begin bx.push_back(GW/2 - i); by.push_back(GH/2); end
    mdir = RT; mpend = RT; mcnt = 0;
    mgrow = 0; mwall = 0; mbody = 0; mstep = 0; mq = 0;
  endtask

  function automatic bit hits(int x, int y, int lo, int hi);
    for (int i = lo; i < hi; i++) if (bx[i] == x && by[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_update();
    int kd, nx, ny, old_dir;
    bit fire, grow, committed, live;
    if (restart) begin m_init(); return; end
    committed = 0;
    old_dir = mdir;
    mstep = 0;
    mq = hits(qx, qy, 0, bx.size());
    live = (status == 2'b10) && !mwall && !mbody;
    fire = live && (mcnt == STEP - 1);
    mcnt = (live && !fire) ? mcnt + 1 : 0;
    if (fire) begin
      nx = bx[0] + ((mpend == RT) ? 1 : 0) - ((mpend == LT) ? 1 : 0);
      ny = by[0] + ((mpend == DN) ? 1 : 0) - ((mpend == UP) ? 1 : 0);
      grow = mgrow | apple;
`ifdef SNAKE_WRAP_WALLS_EN
      nx = (nx + GW) % GW;
      ny = (ny + GH) % GH;
`endif
      if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) mwall = 1;
      else if (hits(nx, ny, 1, grow ? bx.size() : bx.size() - 1)) mbody = 1;
      else begin
        bx.push_front(nx); by.push_front(ny);
        if (!(grow && bx.size() <= ML)) begin void'(bx.pop_back()); void'(by.pop_back()); end
        mdir = mpend; mstep = 1; committed = 1;
      end
    end
    if (committed) mgrow = 0;
    else if (apple) mgrow = 1;
    kd = k1 ? UP : k2 ? DN : k3 ? LT : k4 ? RT : -1;
    if (kd >= 0 && (status == 2'b01 || status == 2'b10) && kd != (old_dir ^ 1)) mpend = kd;
  endtask

  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
    chk("head_x", head_x, bx[0]);
    chk("head_y", head_y, by[0]);
    chk("snake_len", snake_len, bx.size());
    chk("hit_wall", hit_wall, mwall);
    chk("hit_body", hit_body, mbody);
    chk("step_pulse", step_pulse, mstep);
    chk("body_at_q", body_at_q, mq);
  endtask

  task automatic step4(logic [3:0] keys, logic ap);
    {k4, k3, k2, k1} = keys; apple = ap;
    tick();
    {k4, k3, k2, k1} = 4'b0; apple = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_restart();
    restart = 1'b1; tick(); restart = 1'b0;
  endtask

  typedef struct {
    logic [1:0] st; logic rs; logic [3:0] keys; logic ap; int idle;
    int ex; int ey; int el; bit ew; bit wc;
  } vec_t;
  vec_t vt[$];

  task automatic add(logic [1:0] st, logic rs, logic [3:0] keys, logic ap, int idle,
                     int ex, int ey, int el, bit ew, bit wc);
    vec_t v;
    v.st = st; v.rs = rs; v.keys = keys; v.ap = ap; v.idle = idle;
    v.ex = ex; v.ey = ey; v.el = el; v.ew = ew; v.wc = wc;
    vt.push_back(v);
  endtask

  initial begin
    int j;
    bit skip;
    m_init();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst head_x", head_x, 20);
    chk("rst head_y", head_y, 15);
    chk("rst len", snake_len, 3);
    chk("rst hit_wall", hit_wall, 0);
    chk("rst hit_body", hit_body, 0);
    chk("rst step_pulse", step_pulse, 0);
    chk("rst body_at_q", body_at_q, 0);

    // Query served while not playing; tail cell hit, one past tail missed.
    qx = 6'd18; qy = 5'd15; tick(); chk("query tail", body_at_q, 1);
    qx = 6'd17; tick();               chk("query past tail", body_at_q, 0);

    add(2'b10, 0, 4'b0000, 0, 3, 21, 15, 3, 0, 0);
    add(2'b10, 0, 4'b0000, 0, 3, 22, 15, 3, 0, 0);
    add(2'b10, 0, 4'b0100, 0, 3, 23, 15, 3, 0, 0);
    add(2'b10, 0, 4'b0001, 0, 0, 23, 15, 3, 0, 0);
    add(2'b10, 0, 4'b1000, 0, 2, 24, 15, 3, 0, 0);
    add(2'b10, 0, 4'b0001, 0, 3, 24, 14, 3, 0, 0);
    for (int k = 1; k <= 13; k++) add(2'b10, 0, 4'b0000, 1, 3, 24, 14 - k, (3 + k > 16) ? 16 : 3 + k, 0, 0);
    add(2'b10, 0, 4'b0000, 1, 3, 24, 0, 16, 0, 0);
    add(2'b10, 0, 4'b0000, 0, 3, 24, 0, 16, 1, 1);
    add(2'b10, 0, 4'b0000, 0, 7, 24, 0, 16, 1, 1);
    add(2'b00, 1, 4'b0000, 0, 0, 20, 15, 3, 0, 0);
    for (int k = 21; k <= 39; k++) add(2'b10, 0, 4'b0000, 0, 3, k, 15, 3, 0, 0);
    add(2'b10, 0, 4'b0000, 0, 3, 39, 15, 3, 1, 1);

    foreach (vt[i]) begin
      status = vt[i].st; restart = vt[i].rs; {k4, k3, k2, k1} = vt[i].keys; apple = vt[i].ap;
      tick();
      restart = 1'b0; {k4, k3, k2, k1} = 4'b0; apple = 1'b0;
      repeat (vt[i].idle) tick();
      skip = 1'b0;
`ifdef SNAKE_WRAP_WALLS_EN
      skip = vt[i].wc;
`endif
      if (!skip) begin
        chk($sformatf("vec%0d head_x", i), head_x, vt[i].ex);
        chk($sformatf("vec%0d head_y", i), head_y, vt[i].ey);
        chk($sformatf("vec%0d len", i), snake_len, vt[i].el);
        chk($sformatf("vec%0d hit_wall", i), hit_wall, vt[i].ew);
        chk($sformatf("vec%0d hit_body", i), hit_body, 0);
      end
    end

    // Len 5 loop: up, left, down runs into a body segment that is not the tail.
    status = 2'b10;
    do_restart();
    step4(4'b0000, 1); step4(4'b0000, 1);
    chk("len5 grown", snake_len, 5);
    step4(4'b0001, 0); step4(4'b0100, 0); step4(4'b0010, 0);
    chk("len5 hit_body", hit_body, 1);
    chk("len5 head_x", head_x, 21);
    chk("len5 head_y", head_y, 14);

    do_restart();
    chk("restart head_x", head_x, 20);
    chk("restart head_y", head_y, 15);
    chk("restart len", snake_len, 3);
    chk("restart hit_body", hit_body, 0);

    // Len 4 same loop steps onto the vacating tail.
    step4(4'b0000, 1);
    step4(4'b0001, 0); step4(4'b0100, 0); step4(4'b0010, 0);
    chk("len4 hit_body", hit_body, 0);
    chk("len4 head_x", head_x, 20);
    chk("len4 head_y", head_y, 15);
    chk("len4 len", snake_len, 4);

    // Asynchronous reset between clock edges, partway through a step interval.
    repeat (2) tick();
    #1 reset = 1'b1;
    #1;
    chk("async head_x", head_x, 20);
    chk("async head_y", head_y, 15);
    chk("async len", snake_len, 3);
    chk("async step_pulse", step_pulse, 0);
    chk("async body_at_q", body_at_q, 0);
    m_init();
    @(negedge clk);
    reset = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0)
        status = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      restart = ($urandom_range(0, 149) == 0);
      k1 = ($urandom_range(0, 19) == 0);
      k2 = ($urandom_range(0, 19) == 0);
      k3 = ($urandom_range(0, 19) == 0);
      k4 = ($urandom_range(0, 19) == 0);
      apple = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) == 1) begin
        j = $urandom_range(0, bx.size() - 1);
        qx = 6'(bx[j]); qy = 5'(by[j]);
      end else begin
        qx = 6'($urandom_range(0, GW - 1)); qy = 5'($urandom_range(0, GH - 1));
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
